// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: IDLE/BUSY/DONE handshake to a data memory with byte lanes, load extension and timeout.
// Optional build macro MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of issuing them.
module mem_access_stage #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ALUResult_m,
  input  logic [31:0] WriteData_m,
  input  logic        MemRead_m,
  input  logic        MemWrite_m,
  input  logic [2:0]  funct3_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ReadData_m,
  output logic        mem_stall,
  output logic        bus_err_m,
  output logic        misalign_m
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  state_t      state_reg;
  logic [7:0]  wait_cnt_reg;
  logic [1:0]  off_reg;
  logic [2:0]  funct3_reg;
  logic        load_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;
  logic        req_reg;
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  be_reg;

  logic        access;
  logic        trap;
  logic        start;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] load_ext;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign access = MemRead_m | MemWrite_m;

`ifdef MISALIGN_TRAP_EN
  assign trap = (state_reg == IDLE) && access &&
                (((funct3_m[1:0] == 2'b01) && ALUResult_m[0]) ||
                 ((funct3_m[1:0] == 2'b10) && (ALUResult_m[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  assign start = (state_reg == IDLE) && access && !trap;

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = WriteData_m;
    case (funct3_m[1:0])
      2'b00: begin
        be_next    = 4'b0001 << ALUResult_m[1:0];
        wdata_next = {4{WriteData_m[7:0]}};
      end
      2'b01: begin
        be_next    = ALUResult_m[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{WriteData_m[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = WriteData_m;
      end
    endcase
  end

  // Lane selection uses the offset captured at issue, since dmem_addr drops the low bits.
  always_comb begin
    load_byte = dmem_rdata[7:0];
    case (off_reg)
      2'd0: load_byte = dmem_rdata[7:0];
      2'd1: load_byte = dmem_rdata[15:8];
      2'd2: load_byte = dmem_rdata[23:16];
      default: load_byte = dmem_rdata[31:24];
    endcase
    load_half = off_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_ext  = dmem_rdata;
    case (funct3_reg[1:0])
      2'b00:   load_ext = {{24{load_byte[7] & ~funct3_reg[2]}}, load_byte};
      2'b01:   load_ext = {{16{load_half[15] & ~funct3_reg[2]}}, load_half};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 8'd0;
      off_reg      <= 2'd0;
      funct3_reg   <= 3'd0;
      load_reg     <= 1'b0;
      rdata_reg    <= 32'd0;
      err_reg      <= 1'b0;
      req_reg      <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
      be_reg       <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          err_reg <= 1'b0;
          if (start) begin
            state_reg    <= BUSY;
            wait_cnt_reg <= 8'd0;
            req_reg      <= 1'b1;
            we_reg       <= MemWrite_m;
            addr_reg     <= {ALUResult_m[31:2], 2'b00};
            be_reg       <= be_next;
            wdata_reg    <= wdata_next;
            off_reg      <= ALUResult_m[1:0];
            funct3_reg   <= funct3_m;
            load_reg     <= ~MemWrite_m;
          end
        end
        BUSY: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (dmem_ack) begin
            state_reg <= DONE;
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            rdata_reg <= load_reg ? load_ext : 32'd0;
            err_reg   <= 1'b0;
          end else if (wait_cnt_reg == LAST_WAIT) begin
            state_reg <= DONE;
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            rdata_reg <= 32'd0;
            err_reg   <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          err_reg   <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign dmem_req   = req_reg;
  assign dmem_we    = we_reg;
  assign dmem_addr  = addr_reg;
  assign dmem_wdata = wdata_reg;
  assign dmem_be    = be_reg;

  // Combinational flags are masked while reset is held so the pipeline sees a quiet stage.
  assign mem_stall  = rst_n && (start || (state_reg == BUSY));
  assign misalign_m = rst_n && trap;
  assign ReadData_m = (state_reg == DONE) ? rdata_reg : 32'd0;
  assign bus_err_m  = (state_reg == DONE) && err_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage (default build): directed cases plus random accesses against a spec-level model.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] ALUResult_m;
  logic [31:0] WriteData_m;
  logic        MemRead_m;
  logic        MemWrite_m;
  logic [2:0]  funct3_m;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] ReadData_m;
  logic        mem_stall;
  logic        bus_err_m;
  logic        misalign_m;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd;
  logic        last_err;
  int          last_stalls;

  mem_access_stage #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ALUResult_m(ALUResult_m), .WriteData_m(WriteData_m),
    .MemRead_m(MemRead_m), .MemWrite_m(MemWrite_m), .funct3_m(funct3_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .ReadData_m(ReadData_m), .mem_stall(mem_stall),
    .bus_err_m(bus_err_m), .misalign_m(misalign_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: byte mask covering the access size at its naturally aligned offset.
  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int nbytes;
    int off;
    nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off    = int'(addr[1:0]) - (int'(addr[1:0]) % nbytes);
    return 4'(((1 << nbytes) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3[1:0] == 2'b00) return (wd & 32'hFF) * 32'h0101_0101;
    if (f3[1:0] == 2'b01) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
    int nbytes;
    int off;
    logic [31:0] v;
    nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off    = int'(addr[1:0]) - (int'(addr[1:0]) % nbytes);
    v      = rd >> (8 * off);
    if (nbytes == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (nbytes == 2) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  // One full access; ack_at = index of the BUSY cycle that acks (>= TO means never).
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdata, input int ack_at);
    int exp_busy;
    logic exp_err;
    logic [31:0] exp_rd;
    int stalls;
    exp_busy = (ack_at < TO) ? ack_at + 1 : TO;
    exp_err  = (ack_at >= TO);
    exp_rd   = (exp_err || wr) ? 32'd0 : model_load(f3, addr, rdata);
    stalls   = 0;

    @(posedge clk); #1;
    ALUResult_m = addr; WriteData_m = wd; MemRead_m = rd; MemWrite_m = wr; funct3_m = f3;
    @(negedge clk);
    check({tag, "_idle_stall"}, 32'(mem_stall), 32'd1);
    check({tag, "_idle_req"}, 32'(dmem_req), 32'd0);
    check({tag, "_misalign"}, 32'(misalign_m), 32'd0);
    check({tag, "_idle_rd"}, ReadData_m, 32'd0);
    stalls += int'(mem_stall);

    for (int i = 0; i < exp_busy; i++) begin
      @(posedge clk); #1;
      if (i == ack_at) begin
        dmem_ack = 1'b1; dmem_rdata = rdata;
      end else begin
        dmem_ack = 1'b0; dmem_rdata = $urandom;
      end
      @(negedge clk);
      check({tag, "_busy_req"}, 32'(dmem_req), 32'd1);
      check({tag, "_busy_we"}, 32'(dmem_we), 32'(wr));
      check({tag, "_busy_addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
      check({tag, "_busy_be"}, 32'(dmem_be), 32'(model_be(f3, addr)));
      if (wr) check({tag, "_busy_wdata"}, dmem_wdata, model_wdata(f3, wd));
      stalls += int'(mem_stall);
    end

    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_rdata = $urandom;
    @(negedge clk);
    check({tag, "_done_stall"}, 32'(mem_stall), 32'd0);
    check({tag, "_done_req"}, 32'(dmem_req), 32'd0);
    check({tag, "_done_rd"}, ReadData_m, exp_rd);
    check({tag, "_done_err"}, 32'(bus_err_m), 32'(exp_err));
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(1 + exp_busy));
    last_rd     = ReadData_m;
    last_err    = bus_err_m;
    last_stalls = stalls;

    @(posedge clk); #1;
    MemRead_m = 1'b0; MemWrite_m = 1'b0;
    @(negedge clk);
    check({tag, "_after_stall"}, 32'(mem_stall), 32'd0);
    check({tag, "_after_req"}, 32'(dmem_req), 32'd0);
    check({tag, "_after_rd"}, ReadData_m, 32'd0);
  endtask

  initial begin
    logic [2:0] ld_f3 [5];
    ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;

    rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    ALUResult_m = 32'h0000_0104; WriteData_m = 32'h1234_5678;
    MemRead_m = 1'b1; MemWrite_m = 1'b0; funct3_m = 3'b010;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", {mem_stall, dmem_req, dmem_we, bus_err_m, misalign_m}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_be", 32'(dmem_be), 32'd0);
    check("rst_rd", ReadData_m, 32'd0);
    MemRead_m = 1'b0;
    #1 rst_n = 1'b1;

    // Non-memory instructions flow through with no stall.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      ALUResult_m = $urandom; WriteData_m = $urandom;
      @(negedge clk);
      check("nonmem_stall", 32'(mem_stall), 32'd0);
      check("nonmem_req", 32'(dmem_req), 32'd0);
    end

    do_access("sw100", 1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0);
    check("sw100_stalls", 32'(last_stalls), 32'd2);
    do_access("lb203", 1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0, 32'h80FF_FF7F, 0);
    check("lb203_val", last_rd, 32'hFFFF_FF80);
    do_access("lbu203", 1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'h80FF_FF7F, 1);
    check("lbu203_val", last_rd, 32'h0000_0080);
    do_access("sh042", 1'b0, 1'b1, 3'b001, 32'h0000_0042, 32'h0000_1234, 32'h0, 0);
    do_access("lw_to", 1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 100);
    check("lw_to_err", 32'(last_err), 32'd1);
    do_access("lw_ack4", 1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, TO - 1);
    check("lw_ack4_val", last_rd, 32'hCAFE_F00D);
    do_access("lw101", 1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h1357_9BDF, 0);
    do_access("both_hi", 1'b1, 1'b1, 3'b001, 32'h0000_0011, 32'h0000_ABCD, 32'h1111_2222, 2);

    // Reset in the middle of BUSY abandons the access.
    @(posedge clk); #1;
    ALUResult_m = 32'h0000_0400; MemRead_m = 1'b1; funct3_m = 3'b010;
    @(posedge clk); #1;
    check("rstbusy_req_before", 32'(dmem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rstbusy_req", 32'(dmem_req), 32'd0);
    check("rstbusy_stall", 32'(mem_stall), 32'd0);
    check("rstbusy_addr", dmem_addr, 32'd0);
    MemRead_m = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hA5A5_A5A5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rstbusy_late_req", 32'(dmem_req), 32'd0);
      check("rstbusy_late_stall", 32'(mem_stall), 32'd0);
      check("rstbusy_late_rd", ReadData_m, 32'd0);
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;

    for (int n = 0; n < 40; n++) begin
      logic wr;
      logic rd;
      logic [2:0] f3;
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      f3 = wr ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      do_access("rand", rd, wr, f3, $urandom, $urandom, $urandom, $urandom_range(0, TO + 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
